// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcode/funct
// values, FSM state encoding, instruction classes and the select/ALU codes
// that the datapath and ALU decode as well.
package multicycle_ctrl_pkg;

    // Datapath/PC width; the controller itself has no width-dependent logic.
    localparam int unsigned ADDR_W    = 32;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned SEL_W     = 2;

    // Primary opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd3;

    // PC source select
    localparam logic [SEL_W-1:0] PCSRC_BRANCH = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_RS     = 2'd2;

    // Register file destination select
    localparam logic [SEL_W-1:0] REGDST_RT = 2'd0;
    localparam logic [SEL_W-1:0] REGDST_RD = 2'd1;
    localparam logic [SEL_W-1:0] REGDST_RA = 2'd2;

    // Register file write-data select
    localparam logic [SEL_W-1:0] M2R_ALU = 2'd0;
    localparam logic [SEL_W-1:0] M2R_MEM = 2'd1;
    localparam logic [SEL_W-1:0] M2R_PC  = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_ADD  = 4'd1,
        CLS_SUB  = 4'd2,
        CLS_SLT  = 4'd3,
        CLS_JR   = 4'd4,
        CLS_LW   = 4'd5,
        CLS_SW   = 4'd6,
        CLS_J    = 4'd7,
        CLS_JAL  = 4'd8,
        CLS_BNE  = 4'd9,
        CLS_XORI = 4'd10
    } instr_cls_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   opcode/funct/zero : instruction fields and ALU flag, driven by datapath
//   pc_*, ir_write, reg_*, mem_*, alu_*, illegal : controller strobes/selects
// master = datapath side, slave = controller side.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OP_W-1:0]     opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                zero;

    logic                pc_enable;
    logic                pc_load;
    logic [SEL_W-1:0]    pc_src;
    logic                ir_write;
    logic                reg_write;
    logic [SEL_W-1:0]    reg_dst;
    logic [SEL_W-1:0]    mem_to_reg;
    logic                mem_write;
    logic                alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;

    modport master (
        output opcode, funct, zero,
        input  pc_enable, pc_load, pc_src, ir_write, reg_write, reg_dst,
               mem_to_reg, mem_write, alu_src_b, alu_op, illegal
    );

    modport slave (
        input  opcode, funct, zero,
        output pc_enable, pc_load, pc_src, ir_write, reg_write, reg_dst,
               mem_to_reg, mem_write, alu_src_b, alu_op, illegal
    );

endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Combinational instruction classifier.
//   i_opcode    : instr[31:26]
//   i_funct     : instr[5:0], only meaningful for R-type
//   o_cls_c     : instruction class (CLS_NOP when unsupported)
//   o_illegal_c : high for any unsupported opcode/funct combination
module multicycle_ctrl_instr_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    i_opcode,
    input  logic [FUNCT_W-1:0] i_funct,
    output instr_cls_e         o_cls_c,
    output logic               o_illegal_c
);

    // opcode/funct -> class
    always_comb begin
        o_cls_c     = CLS_NOP;
        o_illegal_c = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_cls_c = CLS_ADD;
                    FN_SUB:  o_cls_c = CLS_SUB;
                    FN_SLT:  o_cls_c = CLS_SLT;
                    FN_JR:   o_cls_c = CLS_JR;
                    default: o_illegal_c = 1'b1;
                endcase
            end
            OP_LW:   o_cls_c = CLS_LW;
            OP_SW:   o_cls_c = CLS_SW;
            OP_J:    o_cls_c = CLS_J;
            OP_JAL:  o_cls_c = CLS_JAL;
            OP_BNE:  o_cls_c = CLS_BNE;
            OP_XORI: o_cls_c = CLS_XORI;
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Outputs are Moore-style (state + latched instruction class); the only
// input-dependent outputs are illegal (DECODE) and pc_load for BNE (EXEC).
//   clk   : system clock
//   reset : synchronous, active-high; forces all strobes low in its cycle
//   bus   : controller side of multicycle_ctrl_if (instr fields in,
//           datapath strobes and selects out)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.slave   bus
);

    state_e              r_state;
    state_e              w_state_nxt;
    instr_cls_e          r_cls;
    instr_cls_e          w_cls_nxt;
    instr_cls_e          w_dec_cls;
    logic                w_dec_illegal;

    logic                w_pc_enable;
    logic                w_pc_load;
    logic [SEL_W-1:0]    w_pc_src;
    logic                w_ir_write;
    logic                w_reg_write;
    logic [SEL_W-1:0]    w_reg_dst;
    logic [SEL_W-1:0]    w_mem_to_reg;
    logic                w_mem_write;
    logic                w_alu_src_b;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic                w_illegal;

    multicycle_ctrl_instr_decode u_decode (
        .i_opcode    (bus.opcode),
        .i_funct     (bus.funct),
        .o_cls_c     (w_dec_cls),
        .o_illegal_c (w_dec_illegal)
    );

    // State and latched-class registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_cls   <= CLS_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_cls   <= w_cls_nxt;
        end
    end

    // Next state and datapath controls
    always_comb begin
        w_state_nxt  = ST_FETCH;
        w_cls_nxt    = r_cls;
        w_pc_enable  = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_src     = PCSRC_BRANCH;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = REGDST_RT;
        w_mem_to_reg = M2R_ALU;
        w_mem_write  = 1'b0;
        w_alu_src_b  = 1'b0;
        w_alu_op     = ALU_ADD;
        w_illegal    = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_enable = 1'b1;
                w_state_nxt = ST_DECODE;
            end

            ST_DECODE: begin
                // Class is captured here; IR is stable from DECODE onward.
                w_cls_nxt = w_dec_cls;
                if (w_dec_illegal) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                case (r_cls)
                    CLS_ADD: begin
                        w_alu_op    = ALU_ADD;
                        w_state_nxt = ST_WB;
                    end
                    CLS_SUB: begin
                        w_alu_op    = ALU_SUB;
                        w_state_nxt = ST_WB;
                    end
                    CLS_SLT: begin
                        w_alu_op    = ALU_SLT;
                        w_state_nxt = ST_WB;
                    end
                    CLS_XORI: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = ALU_XOR;
                        w_state_nxt = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = ALU_ADD;
                        w_state_nxt = ST_MEM;
                    end
                    CLS_BNE: begin
                        // Compare via SUB; take the branch when operands differ.
                        w_alu_op  = ALU_SUB;
                        w_pc_src  = PCSRC_BRANCH;
                        w_pc_load = ~bus.zero;
                    end
                    CLS_J: begin
                        w_pc_load = 1'b1;
                        w_pc_src  = PCSRC_JUMP;
                    end
                    CLS_JAL: begin
                        // Link writes the already-incremented PC into $31.
                        w_pc_load    = 1'b1;
                        w_pc_src     = PCSRC_JUMP;
                        w_reg_write  = 1'b1;
                        w_reg_dst    = REGDST_RA;
                        w_mem_to_reg = M2R_PC;
                    end
                    CLS_JR: begin
                        w_pc_load = 1'b1;
                        w_pc_src  = PCSRC_RS;
                    end
                    default: w_state_nxt = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                case (r_cls)
                    CLS_SW:  w_mem_write = 1'b1;
                    CLS_LW:  w_state_nxt = ST_WB;
                    default: w_state_nxt = ST_FETCH;
                endcase
            end

            ST_WB: begin
                case (r_cls)
                    CLS_ADD, CLS_SUB, CLS_SLT: begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = REGDST_RD;
                    end
                    CLS_XORI: w_reg_write = 1'b1;
                    CLS_LW: begin
                        w_reg_write  = 1'b1;
                        w_mem_to_reg = M2R_MEM;
                    end
                    default: w_reg_write = 1'b0;
                endcase
            end

            // Unreachable encodings recover to FETCH with everything low.
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Strobes are suppressed while reset is asserted; selects pass through.
    assign bus.pc_enable  = w_pc_enable & ~reset;
    assign bus.pc_load    = w_pc_load   & ~reset;
    assign bus.ir_write   = w_ir_write  & ~reset;
    assign bus.reg_write  = w_reg_write & ~reset;
    assign bus.mem_write  = w_mem_write & ~reset;
    assign bus.illegal    = w_illegal   & ~reset;
    assign bus.pc_src     = w_pc_src;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle tables plus
// hand-written sequences for reset abort, zero masking and class latching.
module tb_multicycle_ctrl;

    logic clk;
    logic reset;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed in a fixed order:
    // {pc_enable, pc_load, pc_src[1:0], ir_write, reg_write, reg_dst[1:0],
    //  mem_to_reg[1:0], mem_write, alu_src_b, alu_op[2:0], illegal}
    logic [15:0] w_got;
    assign w_got = {bus.pc_enable, bus.pc_load, bus.pc_src, bus.ir_write,
                    bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.mem_write,
                    bus.alu_src_b, bus.alu_op, bus.illegal};

    function automatic logic [15:0] o(
        input logic       pce, input logic pcl, input logic [1:0] pcs,
        input logic       irw, input logic rw,  input logic [1:0] rd,
        input logic [1:0] m2r, input logic mw,  input logic asb,
        input logic [2:0] aop, input logic ill);
        return {pce, pcl, pcs, irw, rw, rd, m2r, mw, asb, aop, ill};
    endfunction

    typedef struct {
        string          name;
        logic [5:0]     op;
        logic [5:0]     fn;
        logic           zero;
        int             lat;
        logic [4:0][15:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [15:0] exp);
        n_tests++;
        if (w_got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%04h expected=%04h", nm, w_got, exp);
        end
    endtask

    // Sample one cycle at the falling edge, then move past the next rising edge.
    task automatic step(input string nm, input logic [15:0] exp);
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op,
                                input logic [5:0] fn, input logic z, input int lat,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3,
                                input logic [15:0] e4);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.zero = z; v.lat = lat;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    logic [15:0] F, Z, E_SUB, E_SLT, E_XORI, E_MA, W_RD, W_RT, W_LW, M_SW;
    logic [15:0] E_BNE_NT, E_BNE_T, E_J, E_JAL, E_JR, D_ILL;

    initial begin
        F        = o(1, 0, 2'd0, 1, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0);
        Z        = 16'h0000;
        E_SUB    = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd1, 0);
        E_SLT    = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd3, 0);
        E_XORI   = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 3'd2, 0);
        E_MA     = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 3'd0, 0);
        W_RD     = o(0, 0, 2'd0, 0, 1, 2'd1, 2'd0, 0, 0, 3'd0, 0);
        W_RT     = o(0, 0, 2'd0, 0, 1, 2'd0, 2'd0, 0, 0, 3'd0, 0);
        W_LW     = o(0, 0, 2'd0, 0, 1, 2'd0, 2'd1, 0, 0, 3'd0, 0);
        M_SW     = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 0, 3'd0, 0);
        E_BNE_NT = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd1, 0);
        E_BNE_T  = o(0, 1, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd1, 0);
        E_J      = o(0, 1, 2'd1, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0);
        E_JAL    = o(0, 1, 2'd1, 0, 1, 2'd2, 2'd2, 0, 0, 3'd0, 0);
        E_JR     = o(0, 1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0);
        D_ILL    = o(0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 1);

        vecs[0]  = mk("add",    6'h00, 6'h20, 0, 4, F, Z, Z,        W_RD, Z);
        vecs[1]  = mk("sub",    6'h00, 6'h22, 0, 4, F, Z, E_SUB,    W_RD, Z);
        vecs[2]  = mk("slt",    6'h00, 6'h2A, 1, 4, F, Z, E_SLT,    W_RD, Z);
        vecs[3]  = mk("xori",   6'h0E, 6'h3F, 0, 4, F, Z, E_XORI,   W_RT, Z);
        vecs[4]  = mk("lw",     6'h23, 6'h20, 0, 5, F, Z, E_MA,     Z,    W_LW);
        vecs[5]  = mk("sw",     6'h2B, 6'h00, 1, 4, F, Z, E_MA,     M_SW, Z);
        vecs[6]  = mk("bne_z1", 6'h05, 6'h00, 1, 3, F, Z, E_BNE_NT, Z,    Z);
        vecs[7]  = mk("bne_z0", 6'h05, 6'h00, 0, 3, F, Z, E_BNE_T,  Z,    Z);
        vecs[8]  = mk("j",      6'h02, 6'h08, 0, 3, F, Z, E_J,      Z,    Z);
        vecs[9]  = mk("jal",    6'h03, 6'h00, 0, 3, F, Z, E_JAL,    Z,    Z);
        vecs[10] = mk("jr",     6'h00, 6'h08, 1, 3, F, Z, E_JR,     Z,    Z);
        vecs[11] = mk("ill_op", 6'h3F, 6'h20, 0, 2, F, D_ILL, Z,    Z,    Z);
        vecs[12] = mk("ill_fn", 6'h00, 6'h21, 0, 2, F, D_ILL, Z,    Z,    Z);

        // Reset held for two rising edges with an ADD already on the bus.
        reset      = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h20;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_strobes", Z);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table: each instruction runs from its FETCH to the next FETCH.
        for (int v = 0; v < NV; v++) begin
            bus.opcode = vecs[v].op;
            bus.funct  = vecs[v].fn;
            bus.zero   = vecs[v].zero;
            for (int c = 0; c < vecs[v].lat; c++)
                step($sformatf("%s.c%0d", vecs[v].name, c), vecs[v].exp[c]);
        end

        // zero is only honoured in EXEC.
        bus.opcode = 6'h05;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        step("bne_mask.fetch", F);
        step("bne_mask.decode", Z);
        bus.zero = 1'b1;
        step("bne_mask.exec", E_BNE_NT);
        bus.zero = 1'b0;

        // Class is latched in DECODE; later IR changes do not affect it.
        bus.opcode = 6'h0E;
        step("xori_latch.fetch", F);
        step("xori_latch.decode", Z);
        bus.opcode = 6'h3F;
        step("xori_latch.exec", E_XORI);
        step("xori_latch.wb", W_RT);

        // Reset during MEM of SW abandons the store.
        bus.opcode = 6'h2B;
        step("sw_rst.fetch", F);
        step("sw_rst.decode", Z);
        step("sw_rst.exec", E_MA);
        reset = 1'b1;
        step("sw_rst.mem", Z);
        reset = 1'b0;
        step("sw_full.fetch", F);
        step("sw_full.decode", Z);
        step("sw_full.exec", E_MA);
        step("sw_full.mem", M_SW);
        step("sw_full.next_fetch", F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle CPU; sits directly upstream of the program counter and drives its increment enable.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB.
- Produces all datapath strobes: IR write, register file write, memory write, ALU op, mux selects, PC load.
- Decodes opcode/funct from the instruction register, which is stable from DECODE onward.

Parameters:
- ADDR_W, 32, datapath/PC width (informational; no width-dependent logic here).

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0] from instruction register.
- zero  in  1  ALU zero flag, valid during EXEC.
- pc_enable  out  1  PC += 4 strobe to program counter.
- pc_load  out  1  PC overwrite strobe (jump/branch).
- pc_src  out  2  0=branch target, 1=jump target, 2=rs register.
- ir_write  out  1  capture instruction memory output into IR.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  0=ALU result, 1=memory data, 2=PC (link).
- mem_write  out  1  data memory write enable.
- alu_src_b  out  1  0=rt, 1=sign/zero-extended immediate.
- alu_op  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT.
- illegal  out  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset has priority over everything. On a reset edge, state goes to FETCH and the latched class goes to NOP.
- During the reset-asserted cycle, all strobes (pc_enable, pc_load, ir_write, reg_write, mem_write, illegal) are forced to 0.
- Reset mid-instruction abandons it; no strobe fires on that edge.
- Outputs are Moore-style: combinational from state plus the latched instruction class. Selects default to 0 when unused.
- Class encodings:
  - LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E.
  - R-type is opcode 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- Class is decoded combinationally in DECODE and latched on the DECODE->next edge.
- FETCH: ir_write=1, pc_enable=1 for exactly this one cycle. Next state is DECODE.
- DECODE: no strobes. Next state is EXEC for valid classes. An unknown opcode/funct asserts illegal=1 and returns to FETCH.
- EXEC, per class:
  - ADD/SUB/SLT: alu_src_b=0, alu_op per funct. Next state WB.
  - XORI: alu_src_b=1, alu_op=XOR. Next state WB.
  - LW/SW: alu_src_b=1, alu_op=ADD. Next state MEM.
  - BNE: alu_op=SUB, pc_src=0, pc_load = ~zero. Next state FETCH.
  - J: pc_load=1, pc_src=1. Next state FETCH.
  - JAL: pc_load=1, pc_src=1, reg_write=1, reg_dst=2, mem_to_reg=2. Next state FETCH.
  - JR: pc_load=1, pc_src=2. Next state FETCH.
- MEM:
  - SW: mem_write=1. Next state FETCH.
  - LW: no strobe. Next state WB.
- WB: reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - XORI: reg_dst=0, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - Next state FETCH.
- Latency in cycles:
  - R-type and XORI: 4.
  - LW: 5.
  - SW: 4.
  - BNE, J, JAL, JR: 3.
  - Illegal: 2.
- pc_enable is never asserted in the same cycle as pc_load.
- PC increments once per instruction, at the end of FETCH. Branch/jump targets are computed from the already-incremented PC.
- The zero flag is ignored outside EXEC.
- Unreachable state encodings go to FETCH on the next edge with all strobes 0.

Decomposition:
- Shared package holds:
  - Opcode and funct localparams.
  - State encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4).
  - alu_op, pc_src, reg_dst and mem_to_reg codes (also used by the datapath and ALU).
- One natural sub-module: instr_decode, combinational opcode/funct -> class + illegal flag.

Test Plan:
- Reset held 2 cycles, then released with opcode=0x00/funct=0x20 -> FETCH/DECODE/EXEC/WB, i.e. pc_enable=1 at cycle 0, reg_write=1 reg_dst=1 at cycle 3, next pc_enable at cycle 4.
- LW 0x23 -> mem_write never asserted; reg_write=1 mem_to_reg=1 in cycle 4; 5-cycle period between pc_enable pulses.
- BNE 0x05 with zero=1 -> pc_load=0 throughout. With zero=0 -> pc_load=1 pc_src=0 in EXEC only; 3-cycle period.
- JAL 0x03 -> in EXEC pc_load=1, pc_src=1, reg_write=1, reg_dst=2, mem_to_reg=2; pc_enable=0 in the same cycle.
- opcode=0x3F -> illegal=1 for one cycle in DECODE, no write strobes, back to FETCH.
- Reset asserted during MEM of SW -> mem_write=0 on that cycle; state=FETCH next cycle; a full SW then completes normally.
